// File: rtl/freq_sweep_ctrl.sv
// Frequency sweep sequencer: steps a DDS frequency word, waits for the synth core to settle,
// averages demodulated I/Q per point and hands each result out over a valid/ready port.
module freq_sweep_ctrl #(
   parameter int SETTLE   = 4096,
   parameter int AVG_LOG2 = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [13:0]        f_start,
   input  logic [13:0]        f_step,
   input  logic [7:0]         n_points,
   input  logic               replay_en,
   input  logic signed [9:0]  I,
   input  logic signed [9:0]  Q,
   output logic [13:0]        freq,
   output logic               ctrl,
   output logic signed [9:0]  I_o,
   output logic signed [9:0]  Q_o,
   output logic               busy,
   output logic               done,
   output logic               res_valid,
   input  logic               res_ready,
   output logic signed [9:0]  res_I,
   output logic signed [9:0]  res_Q,
   output logic [7:0]         res_idx
);

   localparam int ACC_W  = 10 + AVG_LOG2;
   localparam int CNT_W  = 16;
   localparam int ACNT_W = AVG_LOG2 + 1;

   typedef enum logic [2:0] {ST_IDLE, ST_SETTLE, ST_ACCUM, ST_PUSH, ST_DONE} state_t;

   state_t                   r_state, w_next;
   logic [7:0]               r_n_points;
   logic [13:0]              r_f_step;
   logic [13:0]              r_freq;
   logic                     r_ctrl;
   logic signed [9:0]        r_i_o, r_q_o;
   logic                     r_busy, r_done, r_res_valid;
   logic signed [9:0]        r_res_i, r_res_q;
   logic [7:0]               r_res_idx;
   logic                     r_have_result;
   logic [CNT_W-1:0]         r_scnt;
   logic [ACNT_W-1:0]        r_acnt;
   logic signed [ACC_W-1:0]  r_acc_i, r_acc_q;

   logic                     w_start_ok, w_settle_last, w_accum_last, w_xfer, w_last_point;
   logic                     w_have_next;
   logic signed [ACC_W-1:0]  w_sum_i, w_sum_q, w_avg_i, w_avg_q;

   assign w_start_ok    = start & ~r_res_valid;
   assign w_settle_last = (r_scnt == CNT_W'(SETTLE - 1));
   assign w_accum_last  = (r_acnt == ACNT_W'((1 << AVG_LOG2) - 1));
   assign w_xfer        = r_res_valid & res_ready;
   assign w_last_point  = (r_res_idx == r_n_points - 8'd1);
   assign w_have_next   = r_have_result | ((r_state == ST_PUSH) & w_xfer);

   // Accumulators are wide enough for 2^AVG_LOG2 full-scale samples, so the sum never overflows.
   assign w_sum_i = r_acc_i + ACC_W'(I);
   assign w_sum_q = r_acc_q + ACC_W'(Q);
   assign w_avg_i = w_sum_i >>> AVG_LOG2;
   assign w_avg_q = w_sum_q >>> AVG_LOG2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:   if (w_start_ok) w_next = (n_points == 8'd0) ? ST_DONE : ST_SETTLE;
         ST_SETTLE: if (w_settle_last) w_next = ST_ACCUM;
         ST_ACCUM:  if (w_accum_last) w_next = ST_PUSH;
         ST_PUSH:   if (w_xfer) w_next = w_last_point ? ST_DONE : ST_SETTLE;
         ST_DONE:   w_next = ST_IDLE;
         default:   w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_n_points    <= '0;
         r_f_step      <= '0;
         r_freq        <= '0;
         r_ctrl        <= 1'b0;
         r_i_o         <= '0;
         r_q_o         <= '0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_res_valid   <= 1'b0;
         r_res_i       <= '0;
         r_res_q       <= '0;
         r_res_idx     <= '0;
         r_have_result <= 1'b0;
         r_scnt        <= '0;
         r_acnt        <= '0;
         r_acc_i       <= '0;
         r_acc_q       <= '0;
      end else begin
         // Replay select is suppressed while the core is settling or being measured.
         r_ctrl <= replay_en & w_have_next & (w_next != ST_SETTLE) & (w_next != ST_ACCUM);
         r_done <= (w_next == ST_DONE);
         case (r_state)
            ST_IDLE: begin
               if (w_start_ok && n_points != 8'd0) begin
                  r_n_points <= n_points;
                  r_f_step   <= f_step;
                  r_freq     <= f_start;
                  r_res_idx  <= '0;
                  r_busy     <= 1'b1;
                  r_scnt     <= '0;
                  r_acnt     <= '0;
                  r_acc_i    <= '0;
                  r_acc_q    <= '0;
               end
            end
            ST_SETTLE: begin
               r_scnt <= w_settle_last ? '0 : r_scnt + CNT_W'(1);
            end
            ST_ACCUM: begin
               r_acc_i <= w_sum_i;
               r_acc_q <= w_sum_q;
               r_acnt  <= r_acnt + ACNT_W'(1);
               if (w_accum_last) begin
                  r_acnt      <= '0;
                  r_res_i     <= w_avg_i[9:0];
                  r_res_q     <= w_avg_q[9:0];
                  r_res_valid <= 1'b1;
               end
            end
            ST_PUSH: begin
               if (w_xfer) begin
                  r_res_valid   <= 1'b0;
                  r_i_o         <= r_res_i;
                  r_q_o         <= r_res_q;
                  r_have_result <= 1'b1;
                  if (w_last_point) begin
                     r_busy <= 1'b0;
                  end else begin
                     r_freq    <= r_freq + r_f_step;
                     r_res_idx <= r_res_idx + 8'd1;
                     r_acc_i   <= '0;
                     r_acc_q   <= '0;
                     r_scnt    <= '0;
                  end
               end
            end
            ST_DONE: begin
               r_busy <= 1'b0;
            end
            default: begin
               r_busy <= 1'b0;
            end
         endcase
      end
   end

   assign freq      = r_freq;
   assign ctrl      = r_ctrl;
   assign I_o       = r_i_o;
   assign Q_o       = r_q_o;
   assign busy      = r_busy;
   assign done      = r_done;
   assign res_valid = r_res_valid;
   assign res_I     = r_res_i;
   assign res_Q     = r_res_q;
   assign res_idx   = r_res_idx;

endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// Directed bench for freq_sweep_ctrl: expected results are queued at stimulus time and
// compared by a monitor whenever a result transfers.
module tb_freq_sweep_ctrl;

   localparam int SETTLE   = 4;
   localparam int AVG_LOG2 = 2;

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic [13:0]        f_start, f_step;
   logic [7:0]         n_points;
   logic               replay_en;
   logic signed [9:0]  I, Q;
   logic               res_ready;
   logic [13:0]        freq;
   logic               ctrl;
   logic signed [9:0]  I_o, Q_o;
   logic               busy, done, res_valid;
   logic signed [9:0]  res_I, res_Q;
   logic [7:0]         res_idx;

   freq_sweep_ctrl #(.SETTLE(SETTLE), .AVG_LOG2(AVG_LOG2)) dut (
      .clk(clk), .rst(rst), .start(start), .f_start(f_start), .f_step(f_step),
      .n_points(n_points), .replay_en(replay_en), .I(I), .Q(Q), .freq(freq), .ctrl(ctrl),
      .I_o(I_o), .Q_o(Q_o), .busy(busy), .done(done), .res_valid(res_valid),
      .res_ready(res_ready), .res_I(res_I), .res_Q(res_Q), .res_idx(res_idx)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]        idx;
      logic signed [9:0] i;
      logic signed [9:0] q;
      logic [13:0]       f;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int errors = 0;
   int done_cnt = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic push_exp(input logic [7:0] idx, input logic signed [9:0] i,
                           input logic signed [9:0] q, input logic [13:0] f);
      exp_t e;
      e.idx = idx; e.i = i; e.q = q; e.f = f;
      sb.push_back(e);
   endtask

   task automatic wait_done(input int max);
      int n = 0;
      while (!done && n < max) begin
         step();
         n++;
      end
      chk("done_within_bound", {63'd0, done}, 64'd1);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // Result monitor: one line per transfer, compared against the head of the queue.
   always @(negedge clk) begin : mon
      exp_t e;
      if (done) done_cnt++;
      if (!rst && res_valid && res_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL unexpected_result observed idx=%0d expected=none", res_idx);
         end else begin
            e = sb.pop_front();
            $display("xfer idx=%0d res_I=%0d res_Q=%0d freq=%0d (exp idx=%0d I=%0d Q=%0d f=%0d)",
                     res_idx, res_I, res_Q, freq, e.idx, e.i, e.q, e.f);
            chk("res_idx", res_idx, e.idx);
            chk("res_I", res_I, e.i);
            chk("res_Q", res_Q, e.q);
            chk("res_freq", freq, e.f);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; start = 1'b0; f_start = '0; f_step = '0; n_points = '0;
      replay_en = 1'b0; I = '0; Q = '0; res_ready = 1'b0;
      step(); step();
      chk("reset_out_a", {freq, ctrl, I_o, Q_o, busy, done, res_valid}, 64'd0);
      chk("reset_out_b", {res_I, res_Q, res_idx}, 64'd0);
      rst = 1'b0;
      step();
      chk("idle_after_reset", {busy, done, res_valid, freq}, 64'd0);

      // Basic three-point sweep with constant I/Q.
      res_ready = 1'b1; I = 10'sd8; Q = -10'sd8;
      f_start = 14'd100; f_step = 14'd50; n_points = 8'd3;
      push_exp(8'd0, 10'sd8, -10'sd8, 14'd100);
      push_exp(8'd1, 10'sd8, -10'sd8, 14'd150);
      push_exp(8'd2, 10'sd8, -10'sd8, 14'd200);
      done_cnt = 0;
      pulse_start();
      chk("t1_busy", {63'd0, busy}, 64'd1);
      chk("t1_freq0", freq, 64'd100);
      wait_done(200);
      chk("t1_busy_in_done", {63'd0, busy}, 64'd0);
      step(); step();
      chk("t1_done_pulses", done_cnt, 64'd1);
      chk("t1_idle", {busy, done, ctrl}, 64'd0);
      chk("t1_sb_empty", sb.size(), 64'd0);

      // Averaging with floor rounding, stall in PUSH, then replay select.
      replay_en = 1'b1; res_ready = 1'b0; I = '0; Q = '0;
      f_start = 14'd7; f_step = 14'd0; n_points = 8'd1;
      push_exp(8'd0, 10'sd1, -10'sd2, 14'd7);
      done_cnt = 0;
      pulse_start();
      chk("t2_ctrl_settle", {63'd0, ctrl}, 64'd0);
      step(); step(); step(); step();
      chk("t2_no_valid_yet", {63'd0, res_valid}, 64'd0);
      I = 10'sd1; Q = -10'sd1; step();
      I = 10'sd2; Q = -10'sd1; step();
      I = 10'sd2; Q = -10'sd1; step();
      I = 10'sd2; Q = -10'sd2; step();
      chk("t2_valid_latency", {63'd0, res_valid}, 64'd1);
      I = 10'sd100; Q = 10'sd100;
      for (int k = 0; k < 20; k++) begin
         step();
         chk("t2_stall_stable", {res_valid, res_I, res_Q, res_idx, freq},
             {1'b1, 10'sd1, -10'sd2, 8'd0, 14'd7});
      end
      chk("t2_no_done_stall", done_cnt, 64'd0);
      res_ready = 1'b1;
      step();
      chk("t2_valid_drop", {63'd0, res_valid}, 64'd0);
      chk("t2_done", {busy, done}, 64'b01);
      chk("t2_ctrl", {63'd0, ctrl}, 64'd1);
      chk("t2_I_o", I_o, 10'sd1);
      chk("t2_Q_o", Q_o, -10'sd2);
      step();
      chk("t2_done_once", {done, ctrl}, 64'b01);

      // Frequency wrap and a start request ignored mid-sweep.
      I = -10'sd5; Q = 10'sd3;
      f_start = 14'd16380; f_step = 14'd10; n_points = 8'd2;
      push_exp(8'd0, -10'sd5, 10'sd3, 14'd16380);
      push_exp(8'd1, -10'sd5, 10'sd3, 14'd6);
      done_cnt = 0;
      pulse_start();
      chk("t3_ctrl_settle", {63'd0, ctrl}, 64'd0);
      chk("t3_freq0", freq, 64'd16380);
      step(); step(); step();
      f_start = 14'd1; f_step = 14'd1; n_points = 8'd5;
      pulse_start();
      wait_done(200);
      step();
      chk("t3_done_pulses", done_cnt, 64'd1);
      chk("t3_freq_hold", freq, 64'd6);
      chk("t3_sb_empty", sb.size(), 64'd0);

      // Zero-point sweep: immediate done, no result.
      n_points = 8'd0; f_start = 14'd999;
      done_cnt = 0;
      pulse_start();
      chk("t4_done", {busy, done, res_valid}, 64'b010);
      chk("t4_freq_unchanged", freq, 64'd6);
      step();
      chk("t4_done_over", {63'd0, done}, 64'd0);

      // Reset while a result is pending.
      res_ready = 1'b0; I = 10'sd4; Q = 10'sd4;
      f_start = 14'd300; f_step = 14'd1; n_points = 8'd1;
      pulse_start();
      begin
         int n = 0;
         while (!res_valid && n < 50) begin
            step();
            n++;
         end
      end
      chk("t5_valid_before_rst", {63'd0, res_valid}, 64'd1);
      done_cnt = 0;
      #1 rst = 1'b1;
      #1;
      chk("t5_rst_out_a", {freq, ctrl, I_o, Q_o, busy, done, res_valid}, 64'd0);
      chk("t5_rst_out_b", {res_I, res_Q, res_idx}, 64'd0);
      step();
      rst = 1'b0;
      step(); step(); step();
      chk("t5_no_done", done_cnt, 64'd0);
      chk("t5_ctrl_cleared", {63'd0, ctrl}, 64'd0);

      res_ready = 1'b1; I = -10'sd3; Q = 10'sd2;
      f_start = 14'd40; f_step = 14'd0; n_points = 8'd1;
      push_exp(8'd0, -10'sd3, 10'sd2, 14'd40);
      pulse_start();
      chk("t5_freq_restart", freq, 64'd40);
      wait_done(100);
      step();
      chk("t5_ctrl_after", {63'd0, ctrl}, 64'd1);
      chk("t5_I_o", I_o, -10'sd3);
      chk("t5_Q_o", Q_o, 10'sd2);
      chk("t5_sb_empty", sb.size(), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
